lane_result_tracker: RTL and testbench



---
 rtl/lane_pkg.sv | 35 +++
 rtl/lane_ema_filter.sv | 36 +++
 rtl/lane_result_tracker.sv | 132 +++++++++++++
 tb/tb_lane_result_tracker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// Shared types and constants for the lane result tracker: fixed-point filter
// state, tracker FSM encoding and the steering message layout.
package lane_pkg;

    localparam int POS_W     = 8;
    localparam int FRAC_BITS = 4;
    localparam int NUM_POS   = 30;
    localparam int FILT_W    = 10;

    // Unsigned filter state: position * 16 (4 fractional bits).
    typedef logic [FILT_W-1:0] filt_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILTER  = 2'd1,
        S_PRESENT = 2'd2
    } tracker_state_t;

    typedef struct packed {
        logic [POS_W-1:0] error;
        logic [POS_W-1:0] pos;
        logic             sample_ok;
        logic             lane_lost;
    } steer_msg_t;

    function automatic logic sample_accept(
        input logic [POS_W-1:0] pos,
        input logic [POS_W-1:0] conf,
        input logic [POS_W-1:0] conf_min,
        input logic [POS_W-1:0] max_pos
    );
        return (conf >= conf_min) && (pos <= max_pos);
    endfunction

endpackage

// File: rtl/lane_ema_filter.sv
// Combinational EMA step on the fixed-point lane position, plus rounding of
// the new value back to an integer position clamped to MAX_POS.
module lane_ema_filter
    import lane_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int MAX_POS     = 29
) (
    input  filt_t            filt_q,
    input  logic [POS_W-1:0] sample,
    input  logic             init,
    output filt_t            filt_next,
    output logic [POS_W-1:0] filt_int
);

    filt_t              sample_fx;
    logic signed [10:0] delta;
    logic signed [10:0] step;
    logic signed [10:0] sum;
    logic        [10:0] rnd;
    logic        [6:0]  rint;

    // sample and filt_q both stay below 1024, so an 11-bit signed delta is exact;
    // the arithmetic shift floors toward -inf.
    always_comb begin
        sample_fx = FILT_W'({sample, 4'b0});
        delta     = $signed({1'b0, sample_fx}) - $signed({1'b0, filt_q});
        step      = delta >>> ALPHA_SHIFT;
        sum       = $signed({1'b0, filt_q}) + step;
        filt_next = init ? sample_fx : FILT_W'(sum);
        rnd       = {1'b0, filt_next} + 11'd8;
        rint      = 7'(rnd >> FRAC_BITS);
        filt_int  = ({1'b0, rint} > POS_W'(MAX_POS)) ? POS_W'(MAX_POS) : {1'b0, rint};
    end

endmodule

// File: rtl/lane_result_tracker.sv
// Qualifies per-row lane results, smooths them with an EMA, tracks lane loss
// and presents a steering message to the downstream stage.
module lane_result_tracker
    import lane_pkg::*;
#(
    parameter int CONF_MIN    = 16,
    parameter int ALPHA_SHIFT = 2,
    parameter int LOST_LIMIT  = 3,
    parameter int CENTER_REF  = 14,
    parameter int MAX_POS     = 29
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             result_valid,
    input  logic [POS_W-1:0] center_pos,
    input  logic [POS_W-1:0] confidence,
    output logic             steer_valid,
    input  logic             steer_ready,
    output logic [POS_W-1:0] steer_error,
    output logic [POS_W-1:0] filt_pos,
    output logic             sample_ok,
    output logic             lane_lost,
    output logic [7:0]       overrun_cnt,
    output logic             busy,
    output tracker_state_t   state_dbg
);

    // Handshake: the message is held stable from steer_valid rising until the
    // cycle where steer_valid && steer_ready; that cycle completes the transfer.
    // steer_ready with steer_valid low has no effect.

    tracker_state_t   state_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] conf_q;
    filt_t            filt_q;
    logic [7:0]       miss_cnt_q;
    logic             init_needed_q;
    logic             steer_valid_q;
    logic [7:0]       overrun_q;
    steer_msg_t       msg_q;

    filt_t            filt_next;
    logic [POS_W-1:0] filt_int;
    logic             accept;
    logic [7:0]       miss_next;

    lane_ema_filter #(
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .MAX_POS     (MAX_POS)
    ) u_ema (
        .filt_q    (filt_q),
        .sample    (pos_q),
        .init      (init_needed_q),
        .filt_next (filt_next),
        .filt_int  (filt_int)
    );

    always_comb begin
        accept    = sample_accept(pos_q, conf_q, POS_W'(CONF_MIN), POS_W'(MAX_POS));
        miss_next = (miss_cnt_q >= 8'(LOST_LIMIT)) ? 8'(LOST_LIMIT) : miss_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pos_q         <= '0;
            conf_q        <= '0;
            filt_q        <= '0;
            miss_cnt_q    <= '0;
            init_needed_q <= 1'b1;
            steer_valid_q <= 1'b0;
            overrun_q     <= '0;
            msg_q         <= '0;
        end else begin
            if (result_valid && state_q != S_IDLE && overrun_q != 8'hFF)
                overrun_q <= overrun_q + 8'd1;

            case (state_q)
                S_IDLE: begin
                    if (result_valid) begin
                        pos_q   <= center_pos;
                        conf_q  <= confidence;
                        state_q <= S_FILTER;
                    end
                end
                S_FILTER: begin
                    if (accept) begin
                        filt_q          <= filt_next;
                        init_needed_q   <= 1'b0;
                        miss_cnt_q      <= '0;
                        msg_q.pos       <= filt_int;
                        msg_q.error     <= filt_int - POS_W'(CENTER_REF);
                        msg_q.sample_ok <= 1'b1;
                        msg_q.lane_lost <= 1'b0;
                    end else begin
                        miss_cnt_q      <= miss_next;
                        msg_q.sample_ok <= 1'b0;
                        if (miss_next == 8'(LOST_LIMIT)) begin
                            init_needed_q   <= 1'b1;
                            msg_q.lane_lost <= 1'b1;
                            msg_q.pos       <= '0;
                            msg_q.error     <= '0;
                        end else begin
                            // msg_q.pos still holds the last accepted position (0 after reset).
                            msg_q.lane_lost <= 1'b0;
                            msg_q.error     <= msg_q.pos - POS_W'(CENTER_REF);
                        end
                    end
                    steer_valid_q <= 1'b1;
                    state_q       <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (steer_ready) begin
                        steer_valid_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign steer_valid = steer_valid_q;
    assign steer_error = msg_q.error;
    assign filt_pos    = msg_q.pos;
    assign sample_ok   = msg_q.sample_ok;
    assign lane_lost   = msg_q.lane_lost;
    assign overrun_cnt = overrun_q;
    assign busy        = (state_q != S_IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_lane_result_tracker.sv
// Directed bench for lane_result_tracker: table of samples with hand-computed
// EMA results, then backpressure/overrun and async-reset sequences.
module tb_lane_result_tracker;
  import lane_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           result_valid = 1'b0;
  logic [7:0]     center_pos = '0;
  logic [7:0]     confidence = '0;
  logic           steer_ready = 1'b0;
  logic           steer_valid;
  logic [7:0]     steer_error;
  logic [7:0]     filt_pos;
  logic           sample_ok;
  logic           lane_lost;
  logic [7:0]     overrun_cnt;
  logic           busy;
  tracker_state_t state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  lane_result_tracker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .result_valid (result_valid),
    .center_pos   (center_pos),
    .confidence   (confidence),
    .steer_valid  (steer_valid),
    .steer_ready  (steer_ready),
    .steer_error  (steer_error),
    .filt_pos     (filt_pos),
    .sample_ok    (sample_ok),
    .lane_lost    (lane_lost),
    .overrun_cnt  (overrun_cnt),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int pos;
    int conf;
    int exp_pos;
    int exp_err;
    int exp_ok;
    int exp_lost;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_result(input int pos, input int conf);
    @(negedge clk);
    result_valid = 1'b1;
    center_pos = 8'(pos);
    confidence = 8'(conf);
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  // called one negedge after result_valid was sampled; expects valid one cycle later
  task automatic wait_valid(input string name);
    int cycles;
    cycles = 0;
    while (!steer_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_latency"}, cycles, 1);
  endtask

  task automatic check_msg(input string name, input int ep, input int ee, input int eok, input int elost);
    check({name, "_valid"}, int'(steer_valid), 1);
    check({name, "_pos"}, int'(filt_pos), ep);
    check({name, "_err"}, int'($signed(steer_error)), ee);
    check({name, "_ok"}, int'(sample_ok), eok);
    check({name, "_lost"}, int'(lane_lost), elost);
  endtask

  task automatic handshake(input string name);
    steer_ready = 1'b1;
    @(negedge clk);
    steer_ready = 1'b0;
    check({name, "_valid_drop"}, int'(steer_valid), 0);
    check({name, "_idle"}, int'(state_dbg), int'(S_IDLE));
  endtask

  task automatic send(input string name, input int pos, input int conf,
                      input int ep, input int ee, input int eok, input int elost);
    pulse_result(pos, conf);
    wait_valid(name);
    check_msg(name, ep, ee, eok, elost);
    handshake(name);
  endtask

  initial begin
    // pos, conf, exp filt_pos, exp error, sample_ok, lane_lost
    vecs[0]  = '{20,  50, 20,  6, 1, 0};  // first sample initialises: 320
    vecs[1]  = '{12,  50, 18,  4, 1, 0};  // 320 -> 288
    vecs[2]  = '{10,   5, 18,  4, 0, 0};
    vecs[3]  = '{10,   5, 18,  4, 0, 0};
    vecs[4]  = '{10,   5,  0,  0, 0, 1};  // third miss: lost
    vecs[5]  = '{ 3,   5,  0,  0, 0, 1};  // stays lost
    vecs[6]  = '{ 8,  40,  8, -6, 1, 0};  // re-init: 128
    vecs[7]  = '{31, 200,  8, -6, 0, 0};  // out of range
    vecs[8]  = '{16,  16, 10, -4, 1, 0};  // conf at CONF_MIN: 128 -> 160
    vecs[9]  = '{29,  15, 10, -4, 0, 0};  // conf just below
    vecs[10] = '{29, 255, 15,  1, 1, 0};  // MAX_POS accepted: 160 -> 236
    vecs[11] = '{ 0, 100, 11, -3, 1, 0};  // 236 -> 177
    vecs[12] = '{ 0, 100,  8, -6, 1, 0};  // -177>>>2 = -45: 177 -> 132
    vecs[13] = '{30, 100,  8, -6, 0, 0};  // one past MAX_POS
    vecs[14] = '{ 4,   2,  8, -6, 0, 0};  // second consecutive miss, not yet lost

    repeat (3) @(negedge clk);
    check("rst_valid", int'(steer_valid), 0);
    check("rst_pos", int'(filt_pos), 0);
    check("rst_err", int'(steer_error), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun_cnt), 0);
    rst_n = 1'b1;

    // ready while idle must not matter
    @(negedge clk);
    steer_ready = 1'b1;
    @(negedge clk);
    steer_ready = 1'b0;
    check("idle_ready_valid", int'(steer_valid), 0);

    for (int i = 0; i < 15; i++)
      send($sformatf("vec%0d", i), vecs[i].pos, vecs[i].conf,
           vecs[i].exp_pos, vecs[i].exp_err, vecs[i].exp_ok, vecs[i].exp_lost);

    // backpressure: 132 + (400-132)>>>2 = 199 -> pos 12
    pulse_result(25, 50);
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      result_valid = (i == 2 || i == 5);
      center_pos = 8'd0;
      confidence = 8'd99;
      check_msg($sformatf("bp_hold%0d", i), 12, -2, 1, 0);
    end
    result_valid = 1'b0;
    @(negedge clk);
    check("bp_overrun", int'(overrun_cnt), 2);
    // result_valid coincident with the completing handshake is dropped too
    steer_ready = 1'b1;
    result_valid = 1'b1;
    @(negedge clk);
    steer_ready = 1'b0;
    result_valid = 1'b0;
    check("hs_drop_valid", int'(steer_valid), 0);
    check("hs_drop_overrun", int'(overrun_cnt), 3);
    @(negedge clk);
    check("hs_drop_busy", int'(busy), 0);
    // filter untouched by drops: 199 -> 249 -> pos 16
    send("after_bp", 25, 50, 16, 2, 1, 0);

    // async reset while presenting
    pulse_result(9, 50);
    wait_valid("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(steer_valid), 0);
    check("arst_pos", int'(filt_pos), 0);
    check("arst_err", int'(steer_error), 0);
    check("arst_overrun", int'(overrun_cnt), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send("post_rst", 5, 50, 5, -9, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
